// File: rtl/pc_branch_unit.sv
// Program-counter unit: run/halt control, run-time programmable branch-target
// table (relative or absolute entries) and a small return-address stack.
module pc_branch_unit #(
  parameter int unsigned PC_W    = 12,
  parameter int unsigned IDX_W   = 8,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned STACK_D = 4
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         start,
  input  logic [PC_W-1:0]              start_addr,
  input  logic                         halt,
  input  logic                         branch,
  input  logic                         call,
  input  logic                         ret,
  input  logic [IDX_W-1:0]             idx,
  input  logic                         wr_en,
  input  logic [IDX_W-1:0]             wr_idx,
  input  logic [PC_W-1:0]              wr_val,
  input  logic                         wr_abs,
  output logic [PC_W-1:0]              pc,
  output logic                         running,
  output logic [$clog2(STACK_D+1)-1:0] sp,
  output logic                         stack_ovf,
  output logic                         stack_unf,
  output logic                         bad_idx
);

  localparam int unsigned SP_W = $clog2(STACK_D + 1);
  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned SI_W = (STACK_D > 1) ? $clog2(STACK_D) : 1;

  typedef enum logic {S_HALT, S_RUN} state_t;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [SP_W-1:0]   sp_q, sp_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              bad_q, bad_d;
  logic [PC_W-1:0]   stk_q [STACK_D];
  logic [PC_W-1:0]   stk_d [STACK_D];
  logic [PC_W-1:0]   tbl_val_q [DEPTH];
  logic [PC_W-1:0]   tbl_val_d [DEPTH];
  logic [DEPTH-1:0]  tbl_abs_q, tbl_abs_d;

  logic              lk_ok;
  logic [AW-1:0]     lk_i;
  logic [PC_W-1:0]   jump_tgt;
  logic [SP_W-1:0]   sp_m1;

  // Lookups read the registered table, so a same-edge write is not yet visible.
  always_comb begin
    lk_ok    = 32'(idx) < DEPTH;
    lk_i     = idx[AW-1:0];
    jump_tgt = pc_q;
    if (lk_ok) begin
      jump_tgt = tbl_abs_q[lk_i] ? tbl_val_q[lk_i] : pc_q + tbl_val_q[lk_i];
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    sp_d      = sp_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    bad_d     = bad_q;
    stk_d     = stk_q;
    tbl_val_d = tbl_val_q;
    tbl_abs_d = tbl_abs_q;
    sp_m1     = sp_q - SP_W'(1);

    if (start) begin
      state_d = S_RUN;
    end else if (halt) begin
      state_d = S_HALT;
    end

    if (start) begin
      pc_d = start_addr;
    end else if (state_q == S_RUN && !halt) begin
      if (ret) begin
        if (sp_q == '0) begin
          pc_d  = pc_q + PC_W'(1);
          unf_d = 1'b1;
        end else begin
          pc_d = stk_q[sp_m1[SI_W-1:0]];
          sp_d = sp_m1;
        end
      end else if (call) begin
        if (sp_q == SP_W'(STACK_D)) begin
          ovf_d = 1'b1;
        end else begin
          stk_d[sp_q[SI_W-1:0]] = pc_q + PC_W'(1);
          sp_d = sp_q + SP_W'(1);
        end
        pc_d = jump_tgt;
        if (!lk_ok) bad_d = 1'b1;
      end else if (branch) begin
        pc_d = jump_tgt;
        if (!lk_ok) bad_d = 1'b1;
      end else begin
        pc_d = pc_q + PC_W'(1);
      end
    end

    if (wr_en) begin
      if (32'(wr_idx) < DEPTH) begin
        tbl_val_d[wr_idx[AW-1:0]] = wr_val;
        tbl_abs_d[wr_idx[AW-1:0]] = wr_abs;
      end else begin
        bad_d = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_HALT;
      pc_q    <= '0;
      sp_q    <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      bad_q   <= 1'b0;
      for (int unsigned i = 0; i < STACK_D; i++) stk_q[i] <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) tbl_val_q[i] <= '0;
      tbl_abs_q    <= '0;
      tbl_val_q[0] <= PC_W'(0) - PC_W'(5);
      tbl_val_q[1] <= PC_W'(20);
      tbl_val_q[2] <= '1;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      sp_q      <= sp_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
      bad_q     <= bad_d;
      stk_q     <= stk_d;
      tbl_val_q <= tbl_val_d;
      tbl_abs_q <= tbl_abs_d;
    end
  end

  assign pc        = pc_q;
  assign running   = (state_q == S_RUN);
  assign sp        = sp_q;
  assign stack_ovf = ovf_q;
  assign stack_unf = unf_q;
  assign bad_idx   = bad_q;

endmodule

// File: tb/tb_pc_branch_unit.sv
// Scoreboard bench for pc_branch_unit: driver pushes model predictions,
// monitor pops and compares after every rising edge.
module tb_pc_branch_unit;

  localparam int PC_M    = 4096;
  localparam int DEPTH   = 16;
  localparam int STACK_D = 4;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        start = 1'b0;
  logic [11:0] start_addr = '0;
  logic        halt = 1'b0;
  logic        branch = 1'b0;
  logic        call = 1'b0;
  logic        ret = 1'b0;
  logic [7:0]  idx = '0;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_idx = '0;
  logic [11:0] wr_val = '0;
  logic        wr_abs = 1'b0;
  logic [11:0] pc;
  logic        running;
  logic [2:0]  sp;
  logic        stack_ovf;
  logic        stack_unf;
  logic        bad_idx;

  pc_branch_unit #(.PC_W(12), .IDX_W(8), .DEPTH(16), .STACK_D(4)) dut (
    .Clk(Clk), .Reset(Reset), .start(start), .start_addr(start_addr),
    .halt(halt), .branch(branch), .call(call), .ret(ret), .idx(idx),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_val(wr_val), .wr_abs(wr_abs),
    .pc(pc), .running(running), .sp(sp), .stack_ovf(stack_ovf),
    .stack_unf(stack_unf), .bad_idx(bad_idx)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int pc;
    int run;
    int sp;
    int ovf;
    int unf;
    int bad;
    int n;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_step  = 0;

  // Reference model: plain integers, a queue for the stack.
  int   m_pc;
  bit   m_run;
  int   m_stk[$];
  bit   m_ovf, m_unf, m_bad;
  int   m_val[DEPTH];
  bit   m_abs[DEPTH];

  function automatic int wrap(input int v);
    return ((v % PC_M) + PC_M) % PC_M;
  endfunction

  task automatic chk(input string name, input int act, input int exp, input int n);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (step %0d)", name, act, exp, n);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_run = 0; m_ovf = 0; m_unf = 0; m_bad = 0;
    m_stk.delete();
    for (int i = 0; i < DEPTH; i++) begin m_val[i] = 0; m_abs[i] = 0; end
    m_val[0] = PC_M - 5;
    m_val[1] = 20;
    m_val[2] = PC_M - 1;
  endtask

  task automatic model_jump(input int ix, output int tgt);
    int off;
    if (ix >= DEPTH) begin
      m_bad = 1;
      tgt   = m_pc;
    end else if (m_abs[ix]) begin
      tgt = m_val[ix];
    end else begin
      off = (m_val[ix] >= PC_M / 2) ? m_val[ix] - PC_M : m_val[ix];
      tgt = wrap(m_pc + off);
    end
  endtask

  task automatic model_step(input bit st, input int sa, input bit hl, input bit br,
                            input bit cl, input bit rt, input int ix,
                            input bit we, input int wi, input int wv, input bit wa);
    int tgt;
    if (st) begin
      m_pc = sa; m_run = 1;
    end else if (!m_run || hl) begin
      if (hl) m_run = 0;
    end else if (rt) begin
      if (m_stk.size() == 0) begin m_pc = wrap(m_pc + 1); m_unf = 1; end
      else m_pc = m_stk.pop_back();
    end else if (cl) begin
      if (m_stk.size() == STACK_D) m_ovf = 1;
      else m_stk.push_back(wrap(m_pc + 1));
      model_jump(ix, tgt);
      m_pc = tgt;
    end else if (br) begin
      model_jump(ix, tgt);
      m_pc = tgt;
    end else begin
      m_pc = wrap(m_pc + 1);
    end
    if (we) begin
      if (wi >= DEPTH) m_bad = 1;
      else begin m_val[wi] = wv; m_abs[wi] = wa; end
    end
  endtask

  task automatic drive(input bit st, input int sa, input bit hl, input bit br,
                       input bit cl, input bit rt, input int ix,
                       input bit we, input int wi, input int wv, input bit wa);
    exp_t e;
    @(negedge Clk);
    start = st; start_addr = 12'(sa); halt = hl; branch = br; call = cl; ret = rt;
    idx = 8'(ix); wr_en = we; wr_idx = 8'(wi); wr_val = 12'(wv); wr_abs = wa;
    model_step(st, sa, hl, br, cl, rt, ix, we, wi, wv, wa);
    n_step++;
    e.pc = m_pc; e.run = m_run; e.sp = m_stk.size();
    e.ovf = m_ovf; e.unf = m_unf; e.bad = m_bad; e.n = n_step;
    sb.push_back(e);
  endtask

  task automatic idle();                 drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic go(input int a);        drive(1, a, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic do_branch(input int i); drive(0, 0, 0, 1, 0, 0, i, 0, 0, 0, 0); endtask
  task automatic do_call(input int i);   drive(0, 0, 0, 0, 1, 0, i, 0, 0, 0, 0); endtask
  task automatic do_ret();               drive(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0); endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_pc"}, pc, 0, n_step);
    chk({tag, "_sp"}, sp, 0, n_step);
    chk({tag, "_running"}, running, 0, n_step);
    chk({tag, "_flags"}, {stack_ovf, stack_unf, bad_idx}, 0, n_step);
  endtask

  // Asserted between edges; outputs must clear before any clock edge.
  task automatic async_reset();
    @(negedge Clk);
    #2;
    Reset = 1'b1;
    start = 0; halt = 0; branch = 0; call = 0; ret = 0; wr_en = 0;
    sb.delete();
    model_reset();
    #1;
    check_reset_state("async_rst");
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  // Monitor: one scoreboard entry per rising edge while out of reset.
  initial begin
    exp_t e;
    forever begin
      @(posedge Clk);
      #1;
      if (!Reset && sb.size() > 0) begin
        e = sb.pop_front();
        chk("pc", pc, e.pc, e.n);
        chk("running", running, e.run, e.n);
        chk("sp", sp, e.sp, e.n);
        chk("stack_ovf", stack_ovf, e.ovf, e.n);
        chk("stack_unf", stack_unf, e.unf, e.n);
        chk("bad_idx", bad_idx, e.bad, e.n);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit st, hl, br, cl, rt, we, wa;
    model_reset();
    #2;
    check_reset_state("reset");
    @(negedge Clk);
    Reset = 1'b0;

    go(12'h010); idle(); idle(); idle();
    go(12'h030); do_branch(0); do_branch(1); do_branch(2); do_branch(5);
    drive(0, 0, 0, 1, 0, 0, 3, 1, 3, 12'h200, 1);
    do_branch(3);
    go(12'h100);
    repeat (5) do_call(3);
    repeat (5) do_ret();
    go(12'hFFF); idle();
    go(12'hFF0); do_branch(1);
    drive(0, 0, 1, 1, 0, 0, 1, 0, 0, 0, 0);
    do_branch(1); do_call(1); idle();
    drive(1, 12'h3A5, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    do_branch(20);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 17, 12'h123, 1);

    for (int k = 0; k < 400; k++) begin
      st = ($urandom_range(0, 99) < 3);
      hl = ($urandom_range(0, 99) < 3);
      rt = ($urandom_range(0, 99) < 15);
      cl = ($urandom_range(0, 99) < 15);
      br = ($urandom_range(0, 99) < 25);
      we = ($urandom_range(0, 99) < 30);
      wa = $urandom_range(0, 1);
      drive(st, $urandom_range(0, PC_M - 1), hl, br, cl, rt, $urandom_range(0, 19),
            we, $urandom_range(0, 19), $urandom_range(0, PC_M - 1), wa);
    end

    go(12'h100); do_call(3); do_call(3);
    async_reset();
    go(12'h050); do_branch(3); do_branch(0); do_ret(); idle();

    repeat (3) @(posedge Clk);
    #2;
    chk("sb_drain", sb.size(), 0, n_step);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_branch_unit.md
Name: pc_branch_unit

Overview:
- Program-counter unit with a run/halt state machine, a writable branch-target table and a return-address stack.
- Parametrised successor to the fixed branch-offset lookup. Table entries are run-time programmable. Each entry is relative (PC+offset) or absolute (PC=value). Call/return is supported.
- Sits between instruction fetch (drives PC to instruction ROM address) and decode/control (supplies branch, call, ret, idx).

Parameters:
- PC_W, 12, PC and offset width; all PC arithmetic modulo 2^PC_W.
- IDX_W, 8, width of table index ports.
- DEPTH, 16, number of table entries (≤ 2^IDX_W).
- STACK_D, 4, return-stack entries.

Ports:
- Clk  in  1  clock; all state on rising edge.
- Reset  in  1  asynchronous, active-high.
- start  in  1  load start_addr into PC, enter RUN.
- start_addr  in  PC_W  start PC.
- halt  in  1  enter HALT, freeze PC.
- branch  in  1  take table entry idx.
- call  in  1  push PC+1, then take table entry idx.
- ret  in  1  pop return address into PC.
- idx  in  IDX_W  table lookup index.
- wr_en  in  1  table write strobe.
- wr_idx  in  IDX_W  table write index.
- wr_val  in  PC_W  offset (relative, two's complement) or target (absolute).
- wr_abs  in  1  entry mode: 1 = absolute, 0 = relative.
- pc  out  PC_W  current PC (registered).
- running  out  1  1 in RUN state.
- sp  out  $clog2(STACK_D+1)  stack occupancy.
- stack_ovf  out  1  sticky: push attempted while full.
- stack_unf  out  1  sticky: pop attempted while empty.
- bad_idx  out  1  sticky: lookup or write with idx ≥ DEPTH.

Behaviour:
- Reset (async):
  - pc=0, state=HALT, running=0, sp=0, all flags 0.
  - Table preset: entry0 = relative −5; entry1 = relative +20; entry2 = relative −1; all others relative 0 (hold).
- States: HALT, RUN.
  - HALT→RUN on start.
  - RUN→HALT on halt (without start).
  - start has priority over halt.
- Per-edge PC priority:
  1. start: pc ← start_addr.
  2. HALT or halt: pc holds; branch, call and ret are ignored (no stack or flag change).
  3. ret: pc ← top of stack, sp−1.
  4. call: push pc+1, sp+1, then jump per entry[idx].
  5. branch: jump per entry[idx].
  6. else: pc ← pc+1.
- Simultaneous call and ret: ret wins, call ignored. call with branch: behaves as call.
- Jump per entry:
  - relative: pc ← pc + sign-extended offset, wrap modulo 2^PC_W.
  - absolute: pc ← value.
- idx ≥ DEPTH on a taken lookup: treated as relative 0 (pc holds), bad_idx set.
- Table write:
  - wr_en writes {wr_abs, wr_val} at the edge; the value is visible to lookups from the next cycle.
  - A same-cycle lookup of the same entry uses the old value.
  - Writes are accepted in both states.
  - wr_idx ≥ DEPTH: write dropped, bad_idx set.
- Stack full (sp = STACK_D) on call: push dropped, stack unchanged, jump still taken, stack_ovf set.
- Stack empty on ret: pc ← pc+1, stack_unf set.
- Wrap: pc = 2^PC_W−1 with no event → 0. A pushed return address also wraps.
- Latency: every control input affects pc at the next rising edge; no combinational input→pc path.
- Flags clear only on Reset.
- Reset asserted mid-run returns immediately to the reset state, including the table preset.

Test Plan:
- Reset, start with start_addr=0x010, 3 idle cycles → pc 0x010, 0x011, 0x012, 0x013; running=1.
- pc=0x030, branch idx=0 → 0x02B. Then branch idx=1 → 0x03F. Then branch idx=2 → 0x03E. Then idx=5 → pc holds at 0x03E, bad_idx=0.
- Write entry 3 absolute 0x200. Same cycle, branch idx=3 → pc follows old entry (hold). Next branch idx=3 → pc=0x200.
- Five calls (STACK_D=4) from pc 0x100, each via entry abs 0x200, then five rets:
  - Returns pop 0x201, 0x201, 0x201, 0x101.
  - Fifth ret gives pc+1 and sets stack_unf.
  - stack_ovf is set after the fifth call.
- pc=0xFFF with no event → 0x000. Relative +20 from 0xFF0 → 0x004.
- halt with branch high → pc frozen, sp unchanged.
- start and halt together → pc=start_addr, running=1.
- Async Reset mid-call sequence → pc=0 and sp=0 immediately, without waiting for a clock edge.
